// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions, matched to outcomes; one registered update per resolve (1 cycle after outcome).
// pred_ready low only when full (excess pushes dropped, overflow sticky); BRQ_STATS_EN builds saturating hit/miss counters.
module branch_resolve_queue #(
  parameter int n          = 32,
  parameter int depth_log2 = 3,
  parameter int cnt_w      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [n-1:0]          pred_PC,
  input  logic                  prediction,
  input  logic                  prediction_ph,
  input  logic                  prediction_gh,
  output logic                  pred_ready,
  input  logic                  outcome_valid,
  input  logic                  outcome,
  input  logic                  flush,
  output logic                  update_valid,
  output logic [n-1:0]          update_PC,
  output logic                  fix_result,
  output logic [1:0]            chooser_dir,
  output logic                  update_hit,
  output logic [depth_log2:0]   occupancy,
  output logic                  overflow,
  output logic                  underflow,
  output logic [cnt_w-1:0]      hit_count,
  output logic [cnt_w-1:0]      miss_count
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2-1:0] PTR_ONE  = 1;
  localparam logic [depth_log2:0]   OCC_ONE  = 1;
  localparam logic [depth_log2:0]   OCC_FULL = (depth_log2 + 1)'(DEPTH);

  typedef struct packed {
    logic [n-1:0] pc;
    logic         pred;
    logic         ph;
    logic         gh;
  } entry_t;

  entry_t entry_mem [DEPTH];

  logic [depth_log2-1:0] head_q, head_d, tail_q, tail_d;
  logic [depth_log2:0]   occ_q, occ_d;
  logic                  upd_vld_q, upd_vld_d;
  logic [n-1:0]          upd_pc_q, upd_pc_d;
  logic                  fix_q, fix_d;
  logic [1:0]            dir_q, dir_d;
  logic                  hit_q, hit_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic   push, pop, empty;
  entry_t wr_entry, rd_entry;
  logic   gh_ok, ph_ok, rd_hit;

  assign empty      = (occ_q == '0);
  assign pred_ready = (occ_q != OCC_FULL);
  // flush squashes same-cycle push/pop; the pop needs entries already resident
  assign push       = pred_valid & pred_ready & ~flush;
  assign pop        = outcome_valid & ~empty & ~flush;

  assign wr_entry = '{pc: pred_PC, pred: prediction, ph: prediction_ph, gh: prediction_gh};
  assign rd_entry = entry_mem[head_q];
  assign gh_ok    = (rd_entry.gh == outcome);
  assign ph_ok    = (rd_entry.ph == outcome);
  assign rd_hit   = (rd_entry.pred == outcome);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    upd_vld_d = pop;
    upd_pc_d  = upd_pc_q;
    fix_d     = fix_q;
    dir_d     = dir_q;
    hit_d     = hit_q;
    ovf_d     = ovf_q | (pred_valid & ~pred_ready & ~flush);
    udf_d     = udf_q | (outcome_valid & empty & ~flush);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
    if (pop) begin
      upd_pc_d = rd_entry.pc;
      fix_d    = outcome;
      // bit0: only gshare was right, bit1: only pshare was right
      dir_d    = {ph_ok & ~gh_ok, gh_ok & ~ph_ok};
      hit_d    = rd_hit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      upd_vld_q <= 1'b0;
      upd_pc_q  <= '0;
      fix_q     <= 1'b0;
      dir_q     <= 2'b00;
      hit_q     <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      upd_vld_q <= upd_vld_d;
      upd_pc_q  <= upd_pc_d;
      fix_q     <= fix_d;
      dir_q     <= dir_d;
      hit_q     <= hit_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) entry_mem[tail_q] <= wr_entry;
  end

`ifdef BRQ_STATS_EN
  localparam logic [cnt_w-1:0] CNT_ONE = 1;
  logic [cnt_w-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (pop && rd_hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + CNT_ONE;
    if (pop && !rd_hit && (miss_cnt_q != '1))  miss_cnt_d = miss_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  assign update_valid = upd_vld_q;
  assign update_PC    = upd_pc_q;
  assign fix_result   = fix_q;
  assign chooser_dir  = dir_q;
  assign update_hit   = hit_q;
  assign occupancy    = occ_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Resolution-side companion to the tournament chooser. It records every prediction issued for an in-flight branch, holds them in order, and matches each to its actual outcome when the outcome arrives some cycles later. For each resolved branch it emits one registered update packet with the PC, the real direction (`fix_result`), the chooser move direction and the hit flag. Predictor tables and the chooser therefore always train on the metadata of the branch actually resolving, never on the current fetch.

## Interface
Parameters:
- `n`, 32: PC width.
- `depth_log2`, 3: queue depth is 2**depth_log2 entries.
- `cnt_w`, 32: width of the hit/miss counters.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pred_valid`  in  1  push request carrying a new in-flight prediction.
- `pred_PC`  in  n  PC of the predicted branch.
- `prediction`  in  1  final chosen direction.
- `prediction_ph`  in  1  pshare direction.
- `prediction_gh`  in  1  gshare direction.
- `pred_ready`  out  1  high when the queue is not full.
- `outcome_valid`  in  1  the oldest branch resolved this cycle.
- `outcome`  in  1  real direction of the oldest branch.
- `flush`  in  1  synchronous squash of all in-flight entries.
- `update_valid`  out  1  one-cycle pulse; the update fields below are valid.
- `update_PC`  out  n  PC of the resolved branch.
- `fix_result`  out  1  real direction, a copy of `outcome`.
- `chooser_dir`  out  2  chooser move: 01 = toward gshare (+1), 10 = toward pshare (-1), 00 = hold.
- `update_hit`  out  1  stored `prediction` equals `outcome`.
- `occupancy`  out  depth_log2+1  current entry count.
- `overflow`  out  1  sticky; a push was dropped.
- `underflow`  out  1  sticky; an outcome arrived with the queue empty.
- `hit_count`, `miss_count`  out  cnt_w  resolution statistics.

## Operation
- **Storage:** a circular buffer with head and tail pointers of depth_log2 bits that wrap modulo the depth. `occupancy` is a separate counter. Each entry holds {PC, prediction, prediction_ph, prediction_gh}.
- **Push:** occurs when `pred_valid & pred_ready`. The entry is written at the tail and the tail increments.
- **Pop:** occurs when `outcome_valid` and `occupancy != 0`. The head entry is read, the update fields are registered and the head increments.
- **Chooser direction:** 01 when the gshare prediction equals `outcome` and the pshare prediction does not. 10 when the pshare prediction equals `outcome` and the gshare prediction does not. 00 when both are correct or both are wrong.
- **Boundary cases:**
  - `pred_valid` while full: the entry is dropped and `overflow` is set. A pop in the same cycle does not rescue it, because `pred_ready` was already low.
  - `outcome_valid` while empty: no update is produced and `underflow` is set. This includes a push into an empty queue on the same edge; a pushed entry cannot be resolved on the edge it is written.
  - Simultaneous push and pop when not full: both take effect and `occupancy` is unchanged.
  - `flush` has priority over both push and pop. Pointers and `occupancy` go to 0, and no `update_valid` is produced. A same-cycle push or outcome is discarded without setting `overflow` or `underflow`. Counters and sticky flags keep their values.
- **Counters:** they saturate at all-ones and never wrap.
- **Reset:** clears pointers, `occupancy`, `update_valid`, `update_PC`, `fix_result`, `chooser_dir`, `update_hit`, `overflow`, `underflow`, `hit_count` and `miss_count` to 0. `pred_ready` is therefore 1 during and after reset. Entry contents need no reset. Reset asserted mid-operation abandons all in-flight entries.

## Timing
- `pred_ready` is derived combinationally from registered `occupancy` only. It never depends on `pred_valid`.
- Update latency: an outcome sampled at edge k gives `update_valid`=1 with all update fields stable during cycle k+1. `update_valid` is low the following cycle unless another pop occurs.
- The minimum prediction-to-resolution distance is one cycle: push at edge k, outcome accepted at edge k+1 at the earliest.
- `occupancy`, `overflow`, `underflow` and the counters update on the same edge as the triggering event.
- Back-to-back outcomes on consecutive cycles produce consecutive update pulses, one per branch, in order.

## Configuration
- `BRQ_STATS_EN` defined: `hit_count` increments on each pop with `update_hit`=1, and `miss_count` increments on each pop with `update_hit`=0. Both saturate.
- `BRQ_STATS_EN` undefined: the counter registers are not built and `hit_count`/`miss_count` are tied to 0. All other behaviour is identical.

## Test plan
- Push PC=0x40 (pred=1, ph=1, gh=0), then outcome=0 two cycles later -> next cycle `update_valid`=1, `update_PC`=0x40, `fix_result`=0, `chooser_dir`=01, `update_hit`=0, `miss_count`=1.
- Push 8 entries with depth_log2=3 -> `pred_ready`=0, `occupancy`=8. A 9th push is dropped and sets `overflow`=1. Eight outcomes then return the PCs in push order across pointer wrap.
- Outcome with the queue empty -> no `update_valid`, `underflow`=1, counters unchanged.
- Three entries queued, then `flush` with a simultaneous outcome -> `occupancy`=0 next cycle, no update, `overflow`/`underflow` remain 0.
- Assert `reset` asynchronously between edges with 4 entries queued -> all outputs are 0 and `pred_ready`=1 immediately, before the next clock edge.
- With `BRQ_STATS_EN` and `cnt_w`=2: drive 5 hits -> `hit_count` saturates at 3. With the macro undefined, both counters stay at 0.
